// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared encodings, FSM state type and vector count for the gate vector checker
package gate_test_pkg;

    // gate_sel encoding
    localparam logic [1:0] GATE_AND  = 2'd0;
    localparam logic [1:0] GATE_OR   = 2'd1;
    localparam logic [1:0] GATE_XOR  = 2'd2;
    localparam logic [1:0] GATE_XNOR = 2'd3;

    // One sweep covers every {a,b} combination of a two-input gate
    localparam int unsigned NUM_VECTORS = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DRIVE  = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden model of the selected two-input gate
module gate_ref_model
    import gate_test_pkg::*;
(
    input  logic [1:0] gate_sel,
    input  logic       a,
    input  logic       b,
    output logic       c
);

    // Expected gate output for the selected function
    always_comb begin
        c = 1'b0;
        case (gate_sel)
            GATE_AND:  c = a & b;
            GATE_OR:   c = a | b;
            GATE_XOR:  c = a ^ b;
            GATE_XNOR: c = ~(a ^ b);
            default:   c = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - sweeps all input vectors through a gate and counts mismatches (option: GATE_VECTOR_CHECKER_FIRST_FAIL_EN)
module gate_vector_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] gate_sel,
    output logic       drive_a,
    output logic       drive_b,
    input  logic       resp_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] first_fail
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(NUM_PASSES - 1);
    localparam logic [1:0] VEC_LAST    = 2'(NUM_VECTORS - 1);

    state_t      state_q, state_d;
    logic [1:0]  gate_q, gate_d;
    logic [1:0]  vec_q, vec_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  pass_cnt_q, pass_cnt_d;
    logic [7:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic        expected;
    logic        mismatch;
    logic        accept;

    gate_ref_model u_ref (
        .gate_sel (gate_q),
        .a        (vec_q[1]),
        .b        (vec_q[0]),
        .c        (expected)
    );

    assign accept   = (state_q == ST_IDLE) && start;
    assign mismatch = (state_q == ST_SAMPLE) && (resp_c != expected);

    // Sequencer: settle each vector, sample it, advance vector/pass, finish
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        pass_cnt_d = pass_cnt_q;
        err_d      = err_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_d     = gate_sel;
                    err_d      = 8'd0;
                    pass_d     = 1'b0;
                    vec_d      = 2'd0;
                    pass_cnt_d = 8'd0;
                    settle_d   = 4'd0;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = 4'd0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
                if (vec_q == VEC_LAST) begin
                    vec_d = 2'd0;
                    if (pass_cnt_q == PASS_LAST) begin
                        // Use err_d so a mismatch in this last sample already clears pass
                        pass_d  = (err_d == 8'd0);
                        state_d = ST_FINISH;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        state_d    = ST_DRIVE;
                    end
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gate_q     <= 2'd0;
            vec_q      <= 2'd0;
            settle_q   <= 4'd0;
            pass_cnt_q <= 8'd0;
            err_q      <= 8'd0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            pass_cnt_q <= pass_cnt_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
        end
    end

`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
    logic [1:0] first_fail_q, first_fail_d;

    // Capture the vector of the first mismatch; err_q==0 marks the first one of the run
    always_comb begin
        first_fail_d = first_fail_q;
        if (accept) begin
            first_fail_d = 2'd0;
        end else if (mismatch && (err_q == 8'd0)) begin
            first_fail_d = vec_q;
        end
    end

    // First-fail capture register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_q <= 2'd0;
        end else begin
            first_fail_q <= first_fail_d;
        end
    end

    assign first_fail = first_fail_q;
`else
    assign first_fail = 2'd0;
`endif

    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_FINISH);
    assign drive_a   = busy & vec_q[1];
    assign drive_b   = busy & vec_q[0];
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb/tb_gate_vector_checker.sv - directed self-checking bench for gate_vector_checker
module tb_gate_vector_checker;

    function automatic int sc_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int pn_of(input int i);
        case (i)
            2:       return 100;
            3:       return 255;
            default: return 1;
        endcase
    endfunction

    function automatic logic gate_fn(input logic [1:0] g, input logic a, input logic b);
        case (g)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
    localparam logic [1:0] FF_EXP = 2'b01;
`else
    localparam logic [1:0] FF_EXP = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start, da, db, rc, bz, dn, ps, stk;
    logic [1:0] gs [4];
    logic [1:0] dg [4];
    logic [1:0] ff [4];
    logic [7:0] ec [4];

    int n_tot  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        gate_vector_checker #(
            .SETTLE_CYCLES (sc_of(gi)),
            .NUM_PASSES    (pn_of(gi))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[gi]),
            .gate_sel   (gs[gi]),
            .drive_a    (da[gi]),
            .drive_b    (db[gi]),
            .resp_c     (rc[gi]),
            .busy       (bz[gi]),
            .done       (dn[gi]),
            .pass       (ps[gi]),
            .err_count  (ec[gi]),
            .first_fail (ff[gi])
        );
    end

    // Gate under test: a behavioural gate of type dg, or stuck at 1
    always_comb begin
        rc = '0;
        for (int i = 0; i < 4; i++) begin
            rc[i] = stk[i] ? 1'b1 : gate_fn(dg[i], da[i], db[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a run on instance i and follow it to done (bounded)
    task automatic go(input int i, input bit hold, output int done_at, output logic [7:0] seq,
                      output logic [7:0] err_at, output logic pass_at, output logic [1:0] ff_at);
        int sc, budget;
        sc      = sc_of(i);
        budget  = 4 * pn_of(i) * (sc + 1) + 5;
        done_at = -1;
        seq     = 8'd0;
        err_at  = 8'hxx;
        pass_at = 1'bx;
        ff_at   = 2'bxx;
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start[i] = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (n <= 4 * (sc + 1) && ((n - 1) % (sc + 1)) == 0) seq = {seq[5:0], da[i], db[i]};
            if (hold && n == 5) gs[i] = 2'd0;
            if (dn[i]) begin
                done_at = n;
                err_at  = ec[i];
                pass_at = ps[i];
                ff_at   = ff[i];
                break;
            end
        end
    endtask

    initial begin
        int         d_at;
        logic [7:0] sq, e_at;
        logic       p_at;
        logic [1:0] f_at;
        int         seen_busy, seen_done, cnt;

        rst_n = 1'b0;
        start = '0;
        stk   = '0;
        for (int i = 0; i < 4; i++) begin
            gs[i] = 2'd0;
            dg[i] = 2'd0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", bz[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_pass", ps[0], 0);
        chk("rst_err", ec[0], 0);
        chk("rst_ff", ff[0], 0);
        chk("rst_da", da[0], 0);
        chk("rst_db", db[0], 0);
        rst_n = 1'b1;
        seen_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (bz != 4'd0) seen_busy++;
        end
        chk("idle_no_run", seen_busy, 0);

        // XOR, correct gate, SETTLE=2
        gs[0] = 2'd2; dg[0] = 2'd2;
        go(0, 1'b0, d_at, sq, e_at, p_at, f_at);
        chk("xor_done_at", d_at, 13);
        chk("xor_seq", sq, 8'h1B);
        chk("xor_pass", p_at, 1);
        chk("xor_err", e_at, 0);
        @(negedge clk);
        chk("xor_done_pulse", dn[0], 0);
        chk("xor_pass_held", ps[0], 1);
        chk("xor_idle_da", da[0], 0);

        // XOR selected, gate is AND
        dg[0] = 2'd0;
        go(0, 1'b0, d_at, sq, e_at, p_at, f_at);
        chk("and_done_at", d_at, 13);
        chk("and_err", e_at, 3);
        chk("and_pass", p_at, 0);
        chk("and_ff", f_at, FF_EXP);

        // OR, correct gate, SETTLE=1
        gs[1] = 2'd1; dg[1] = 2'd1;
        go(1, 1'b0, d_at, sq, e_at, p_at, f_at);
        chk("or_done_at", d_at, 9);
        chk("or_seq", sq, 8'h1B);
        chk("or_pass", p_at, 1);
        chk("or_err", e_at, 0);

        // XNOR, stuck at 1, 100 passes
        gs[2] = 2'd3; stk[2] = 1'b1;
        go(2, 1'b0, d_at, sq, e_at, p_at, f_at);
        chk("p100_done_at", d_at, 801);
        chk("p100_err", e_at, 200);
        chk("p100_pass", p_at, 0);
        chk("p100_ff", f_at, FF_EXP);

        // XNOR, stuck at 1, 255 passes -> saturation
        gs[3] = 2'd3; stk[3] = 1'b1;
        go(3, 1'b0, d_at, sq, e_at, p_at, f_at);
        chk("p255_done_at", d_at, 2041);
        chk("p255_err_sat", e_at, 255);

        // Reset pulsed during the third vector
        gs[0] = 2'd2; dg[0] = 2'd0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_da", da[0], 1);
        chk("mid_db", db[0], 0);
        chk("mid_err", ec[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bz[0], 0);
        chk("arst_da", da[0], 0);
        chk("arst_err", ec[0], 0);
        chk("arst_done", dn[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_busy = 0;
        seen_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (bz[0]) seen_busy++;
            if (dn[0]) seen_done++;
        end
        chk("arst_no_done", seen_done, 0);
        chk("arst_no_restart", seen_busy, 0);
        dg[0] = 2'd2;
        go(0, 1'b0, d_at, sq, e_at, p_at, f_at);
        chk("rerun_done_at", d_at, 13);
        chk("rerun_seq", sq, 8'h1B);
        chk("rerun_pass", p_at, 1);

        // start held high, gate_sel changed mid-run
        gs[0] = 2'd2; dg[0] = 2'd2;
        go(0, 1'b1, d_at, sq, e_at, p_at, f_at);
        chk("hold_done_at", d_at, 13);
        chk("hold_err", e_at, 0);
        chk("hold_pass", p_at, 1);
        @(negedge clk);
        chk("hold_idle_gap", bz[0], 0);
        @(negedge clk);
        chk("hold_restart", bz[0], 1);
        start[0] = 1'b0;
        cnt = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (dn[0]) begin
                cnt = n;
                break;
            end
        end
        chk("run2_done_at", cnt, 12);
        chk("run2_err", ec[0], 3);
        chk("run2_pass", ps[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
